// File: rtl/waveform_dm_pkg.sv
// Shared types, field layouts and helpers for the waveform BRAM datamover
// command/status path.
package waveform_dm_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BTT_W  = 23;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned CMD_W  = 72;
  localparam int unsigned STS_W  = 8;
  localparam int unsigned ERR_W  = 4;

  // Error code bits reported on *_error alongside *_done
  localparam logic [ERR_W-1:0] ERR_STATUS   = 4'b0001;
  localparam logic [ERR_W-1:0] ERR_TAG      = 4'b0010;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 4'b0100;
  localparam logic [ERR_W-1:0] ERR_ZERO_BTT = 4'b1000;

  // DataMover command word, MSB first
  typedef struct packed {
    logic [3:0]        rsvd;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] saddr;
    logic              drr;
    logic              eof;
    logic [5:0]        dsa;
    logic              type_incr;
    logic [BTT_W-1:0]  btt;
  } dm_cmd_t;

  // DataMover status beat, MSB first
  typedef struct packed {
    logic             okay;
    logic             slverr;
    logic             decerr;
    logic             interr;
    logic [TAG_W-1:0] tag;
  } dm_sts_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_STS
  } dm_state_e;

  function automatic dm_cmd_t dm_cmd_pack(input logic [ADDR_W-1:0] saddr,
                                          input logic [BTT_W-1:0]  btt,
                                          input logic [TAG_W-1:0]  tag);
    dm_cmd_t cmd;
    cmd           = '0;
    cmd.btt       = btt;
    cmd.type_incr = 1'b1;
    cmd.eof       = 1'b1;
    cmd.saddr     = saddr;
    cmd.tag       = tag;
    return cmd;
  endfunction

endpackage

// File: rtl/waveform_dm_cmd_ctrl_channel.sv
// One datamover channel: issues a command per request, waits for the status
// beat (or a timeout) and reports completion with an error code.
module dm_cmd_channel
  import waveform_dm_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BTT_W-1:0]  btt,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  error,
  output logic [CMD_W-1:0]  cmd_tdata,
  output logic              cmd_tvalid,
  input  logic              cmd_tready,
  input  logic [STS_W-1:0]  sts_tdata,
  input  logic              sts_tvalid,
  output logic              sts_tready
);

  localparam int unsigned TMR_W = 32;

  dm_state_e         state, state_n;
  dm_cmd_t           cmd_q, cmd_n;
  logic [TAG_W-1:0]  tag_q, tag_n;
  logic [TMR_W-1:0]  tmr_q, tmr_n;
  logic              busy_n, done_n, cmd_tvalid_n, sts_tready_n;
  logic [ERR_W-1:0]  error_n, sts_err;
  dm_sts_t           sts;

  assign sts       = dm_sts_t'(sts_tdata);
  assign cmd_tdata = CMD_W'(cmd_q);

  // Status beat decode against the tag that was issued
  always_comb begin
    sts_err = '0;
    if (!sts.okay || sts.slverr || sts.decerr || sts.interr) sts_err = sts_err | ERR_STATUS;
    if (sts.tag != cmd_q.tag)                                sts_err = sts_err | ERR_TAG;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      cmd_q      <= '0;
      tag_q      <= '0;
      tmr_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= '0;
      cmd_tvalid <= 1'b0;
      sts_tready <= 1'b0;
    end else begin
      state      <= state_n;
      cmd_q      <= cmd_n;
      tag_q      <= tag_n;
      tmr_q      <= tmr_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
      cmd_tvalid <= cmd_tvalid_n;
      sts_tready <= sts_tready_n;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_n      = state;
    cmd_n        = cmd_q;
    tag_n        = tag_q;
    tmr_n        = tmr_q;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    error_n      = '0;
    cmd_tvalid_n = 1'b0;
    sts_tready_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (req) begin
          if (btt != '0) begin
            state_n      = ST_CMD;
            cmd_n        = dm_cmd_pack(ADDR_W'(BASE_ADDR + addr), btt, tag_q);
            cmd_tvalid_n = 1'b1;
            busy_n       = 1'b1;
          end else begin
            done_n  = 1'b1;
            error_n = ERR_ZERO_BTT;
          end
        end
      end
      ST_CMD: begin
        busy_n = 1'b1;
        if (cmd_tready) begin
          state_n      = ST_STS;
          tag_n        = tag_q + TAG_W'(1);
          tmr_n        = '0;
          sts_tready_n = 1'b1;
        end else begin
          cmd_tvalid_n = 1'b1;
        end
      end
      ST_STS: begin
        // A status beat in the same cycle as the timeout wins
        if (sts_tvalid) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          error_n = sts_err;
        end else if (tmr_q == TMR_W'(TIMEOUT)) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          error_n = ERR_TIMEOUT;
        end else begin
          tmr_n        = tmr_q + TMR_W'(1);
          busy_n       = 1'b1;
          sts_tready_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/waveform_dm_cmd_ctrl.sv
// Load (S2MM) and playback (MM2S) command issuers for the waveform BRAM
// datamover, plus a sticky datamover error flag.
module waveform_dm_cmd_ctrl
  import waveform_dm_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       TIMEOUT   = 65535
) (
  input  logic              clk_in1,
  input  logic              aresetn,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BTT_W-1:0]  wr_btt,
  output logic              wr_busy,
  output logic              wr_done,
  output logic [ERR_W-1:0]  wr_error,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BTT_W-1:0]  rd_btt,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [ERR_W-1:0]  rd_error,
  output logic [CMD_W-1:0]  m_axis_s2mm_cmd_tdata,
  output logic              m_axis_s2mm_cmd_tvalid,
  input  logic              m_axis_s2mm_cmd_tready,
  input  logic [STS_W-1:0]  s_axis_s2mm_sts_tdata,
  input  logic              s_axis_s2mm_sts_tkeep,
  input  logic              s_axis_s2mm_sts_tlast,
  input  logic              s_axis_s2mm_sts_tvalid,
  output logic              s_axis_s2mm_sts_tready,
  output logic [CMD_W-1:0]  m_axis_mm2s_cmd_tdata,
  output logic              m_axis_mm2s_cmd_tvalid,
  input  logic              m_axis_mm2s_cmd_tready,
  input  logic [STS_W-1:0]  s_axis_mm2s_sts_tdata,
  input  logic              s_axis_mm2s_sts_tkeep,
  input  logic              s_axis_mm2s_sts_tlast,
  input  logic              s_axis_mm2s_sts_tvalid,
  output logic              s_axis_mm2s_sts_tready,
  input  logic              s2mm_err,
  input  logic              mm2s_err,
  output logic              dm_err_sticky
);

  // Status is always a single beat, so keep/last carry no information
  logic unused_sts_sideband;
  assign unused_sts_sideband = &{1'b0, s_axis_s2mm_sts_tkeep, s_axis_s2mm_sts_tlast,
                                 s_axis_mm2s_sts_tkeep, s_axis_mm2s_sts_tlast};

  dm_cmd_channel #(.BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)) u_s2mm (
    .clk        (clk_in1),
    .aresetn    (aresetn),
    .req        (wr_req),
    .addr       (wr_addr),
    .btt        (wr_btt),
    .busy       (wr_busy),
    .done       (wr_done),
    .error      (wr_error),
    .cmd_tdata  (m_axis_s2mm_cmd_tdata),
    .cmd_tvalid (m_axis_s2mm_cmd_tvalid),
    .cmd_tready (m_axis_s2mm_cmd_tready),
    .sts_tdata  (s_axis_s2mm_sts_tdata),
    .sts_tvalid (s_axis_s2mm_sts_tvalid),
    .sts_tready (s_axis_s2mm_sts_tready)
  );

  dm_cmd_channel #(.BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)) u_mm2s (
    .clk        (clk_in1),
    .aresetn    (aresetn),
    .req        (rd_req),
    .addr       (rd_addr),
    .btt        (rd_btt),
    .busy       (rd_busy),
    .done       (rd_done),
    .error      (rd_error),
    .cmd_tdata  (m_axis_mm2s_cmd_tdata),
    .cmd_tvalid (m_axis_mm2s_cmd_tvalid),
    .cmd_tready (m_axis_mm2s_cmd_tready),
    .sts_tdata  (s_axis_mm2s_sts_tdata),
    .sts_tvalid (s_axis_mm2s_sts_tvalid),
    .sts_tready (s_axis_mm2s_sts_tready)
  );

  always_ff @(posedge clk_in1) begin
    if (!aresetn) dm_err_sticky <= 1'b0;
    else          dm_err_sticky <= dm_err_sticky | s2mm_err | mm2s_err;
  end

endmodule

// File: tb/tb_waveform_dm_cmd_ctrl.sv
// Directed + randomized bench for waveform_dm_cmd_ctrl; channel 0 = load
// (S2MM), channel 1 = playback (MM2S).
module tb_waveform_dm_cmd_ctrl;

  localparam int unsigned TB_TIMEOUT = 20;
  localparam logic [31:0] TB_BASE    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        req [2];
  logic [31:0] addr [2];
  logic [22:0] btt [2];
  logic        busy [2];
  logic        done [2];
  logic [3:0]  err [2];
  logic [71:0] cmd_tdata [2];
  logic        cmd_tvalid [2];
  logic        cmd_tready [2];
  logic [7:0]  sts_tdata [2];
  logic        sts_tvalid [2];
  logic        sts_tready [2];
  logic        s2mm_err, mm2s_err, dm_err_sticky;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  model_tag [2];

  always #5 clk = ~clk;

  waveform_dm_cmd_ctrl #(.BASE_ADDR(TB_BASE), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk_in1                (clk),
    .aresetn                (aresetn),
    .wr_req                 (req[0]),
    .wr_addr                (addr[0]),
    .wr_btt                 (btt[0]),
    .wr_busy                (busy[0]),
    .wr_done                (done[0]),
    .wr_error               (err[0]),
    .rd_req                 (req[1]),
    .rd_addr                (addr[1]),
    .rd_btt                 (btt[1]),
    .rd_busy                (busy[1]),
    .rd_done                (done[1]),
    .rd_error               (err[1]),
    .m_axis_s2mm_cmd_tdata  (cmd_tdata[0]),
    .m_axis_s2mm_cmd_tvalid (cmd_tvalid[0]),
    .m_axis_s2mm_cmd_tready (cmd_tready[0]),
    .s_axis_s2mm_sts_tdata  (sts_tdata[0]),
    .s_axis_s2mm_sts_tkeep  (1'b1),
    .s_axis_s2mm_sts_tlast  (1'b1),
    .s_axis_s2mm_sts_tvalid (sts_tvalid[0]),
    .s_axis_s2mm_sts_tready (sts_tready[0]),
    .m_axis_mm2s_cmd_tdata  (cmd_tdata[1]),
    .m_axis_mm2s_cmd_tvalid (cmd_tvalid[1]),
    .m_axis_mm2s_cmd_tready (cmd_tready[1]),
    .s_axis_mm2s_sts_tdata  (sts_tdata[1]),
    .s_axis_mm2s_sts_tkeep  (1'b1),
    .s_axis_mm2s_sts_tlast  (1'b1),
    .s_axis_mm2s_sts_tvalid (sts_tvalid[1]),
    .s_axis_mm2s_sts_tready (sts_tready[1]),
    .s2mm_err               (s2mm_err),
    .mm2s_err               (mm2s_err),
    .dm_err_sticky          (dm_err_sticky)
  );

  task automatic chk(input string name, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference command word built straight from the documented field layout
  function automatic logic [71:0] ref_cmd(input logic [31:0] a, input logic [22:0] b,
                                          input logic [3:0] tag);
    logic [31:0] saddr;
    saddr = TB_BASE + a;
    return {4'h0, tag, saddr, 1'b0, 1'b1, 6'h0, 1'b1, b};
  endfunction

  // Reference error code: anything but a clean OKAY nibble is a status error
  function automatic logic [3:0] ref_err(input logic [7:0] s, input logic [3:0] tag);
    logic [3:0] e;
    e = 4'h0;
    if ((s >> 4) != 8'd8) e = e + 4'd1;
    if ((s % 16) != 8'(tag)) e = e + 4'd2;
    return e;
  endfunction

  task automatic do_reset();
    aresetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req[c] = 1'b0; cmd_tready[c] = 1'b0; sts_tvalid[c] = 1'b0;
    end
    s2mm_err = 1'b0; mm2s_err = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("rst ch%0d busy", c), 72'(busy[c]), 72'd0);
      chk($sformatf("rst ch%0d done", c), 72'(done[c]), 72'd0);
      chk($sformatf("rst ch%0d error", c), 72'(err[c]), 72'd0);
      chk($sformatf("rst ch%0d tvalid", c), 72'(cmd_tvalid[c]), 72'd0);
      chk($sformatf("rst ch%0d tdata", c), cmd_tdata[c], 72'd0);
      chk($sformatf("rst ch%0d sts_tready", c), 72'(sts_tready[c]), 72'd0);
      model_tag[c] = 4'd0;
    end
    chk("rst sticky", 72'(dm_err_sticky), 72'd0);
    aresetn = 1'b1;
  endtask

  // mode 0: random status, 1: status byte sb, 2: no status (timeout)
  task automatic xfer(input int ch, input logic [31:0] a, input logic [22:0] b,
                      input int stall, input int dly, input int mode, input logic [7:0] sb);
    logic [3:0]  tag;
    logic [71:0] exp_cmd;
    logic [7:0]  s;
    int          cyc;
    tag = model_tag[ch];
    req[ch] = 1'b1; addr[ch] = a; btt[ch] = b;
    @(negedge clk);
    req[ch] = 1'b0;
    if (b == 23'd0) begin
      chk($sformatf("ch%0d zero-btt done", ch), 72'(done[ch]), 72'd1);
      chk($sformatf("ch%0d zero-btt error", ch), 72'(err[ch]), 72'h8);
      chk($sformatf("ch%0d zero-btt tvalid", ch), 72'(cmd_tvalid[ch]), 72'd0);
      chk($sformatf("ch%0d zero-btt busy", ch), 72'(busy[ch]), 72'd0);
      @(negedge clk);
      chk($sformatf("ch%0d zero-btt done drop", ch), 72'(done[ch]), 72'd0);
    end else begin
      exp_cmd = ref_cmd(a, b, tag);
      chk($sformatf("ch%0d tvalid", ch), 72'(cmd_tvalid[ch]), 72'd1);
      chk($sformatf("ch%0d tdata", ch), cmd_tdata[ch], exp_cmd);
      chk($sformatf("ch%0d busy", ch), 72'(busy[ch]), 72'd1);
      for (int i = 0; i < stall; i++) begin
        // a request while busy must be ignored
        req[ch] = (i == 1);
        if (i == 1) begin addr[ch] = ~a; btt[ch] = b ^ 23'h55; end
        @(negedge clk);
        chk($sformatf("ch%0d stall tvalid", ch), 72'(cmd_tvalid[ch]), 72'd1);
        chk($sformatf("ch%0d stall tdata", ch), cmd_tdata[ch], exp_cmd);
      end
      req[ch] = 1'b0;
      cmd_tready[ch] = 1'b1;
      @(negedge clk);
      cmd_tready[ch] = 1'b0;
      model_tag[ch] = model_tag[ch] + 4'd1;
      chk($sformatf("ch%0d post-hs tvalid", ch), 72'(cmd_tvalid[ch]), 72'd0);
      chk($sformatf("ch%0d sts_tready", ch), 72'(sts_tready[ch]), 72'd1);
      if (mode == 2) begin
        cyc = 0;
        while (done[ch] !== 1'b1 && cyc < 100) begin
          @(negedge clk);
          cyc++;
        end
        chk($sformatf("ch%0d timeout latency", ch), 72'(cyc), 72'(TB_TIMEOUT + 1));
        chk($sformatf("ch%0d timeout error", ch), 72'(err[ch]), 72'h4);
        chk($sformatf("ch%0d timeout busy", ch), 72'(busy[ch]), 72'd0);
      end else begin
        for (int d = 0; d < dly; d++) begin
          @(negedge clk);
          chk($sformatf("ch%0d wait busy", ch), 72'(busy[ch]), 72'd1);
          chk($sformatf("ch%0d wait done", ch), 72'(done[ch]), 72'd0);
        end
        if (mode == 1) s = sb;
        else begin
          case ($urandom_range(0, 3))
            0, 1:    s = {4'h8, tag};
            2:       s = {4'($urandom), tag};
            default: s = 8'($urandom);
          endcase
        end
        sts_tdata[ch] = s; sts_tvalid[ch] = 1'b1;
        @(negedge clk);
        sts_tvalid[ch] = 1'b0;
        chk($sformatf("ch%0d done", ch), 72'(done[ch]), 72'd1);
        chk($sformatf("ch%0d error sts=%h", ch, s), 72'(err[ch]), 72'(ref_err(s, tag)));
        chk($sformatf("ch%0d done busy", ch), 72'(busy[ch]), 72'd0);
        chk($sformatf("ch%0d done sts_tready", ch), 72'(sts_tready[ch]), 72'd0);
      end
      @(negedge clk);
      chk($sformatf("ch%0d done single", ch), 72'(done[ch]), 72'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t0;
    aresetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req[c] = 1'b0; addr[c] = '0; btt[c] = '0;
      cmd_tready[c] = 1'b0; sts_tdata[c] = '0; sts_tvalid[c] = 1'b0;
      model_tag[c] = 4'd0;
    end
    s2mm_err = 1'b0; mm2s_err = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic load and a backpressured load
    xfer(0, 32'h100, 23'd4096, 0, 0, 1, 8'h80);
    xfer(0, $urandom, 23'($urandom_range(1, 8388607)), 10, 1, 0, 8'h0);
    xfer(0, $urandom, 23'($urandom_range(1, 8388607)), 0, 0, 1, {4'h8, model_tag[0]});

    // Error codes from a fresh tag 0
    do_reset();
    xfer(1, $urandom, 23'd64, 0, 0, 1, 8'hC0);
    xfer(0, $urandom, 23'd64, 0, 0, 1, 8'h81);
    xfer(0, $urandom, 23'd0, 0, 0, 0, 8'h0);
    xfer(1, $urandom, 23'd0, 0, 0, 0, 8'h0);

    // Timeout, then a stray status beat in IDLE is not accepted
    xfer(1, $urandom, 23'd256, 0, 0, 2, 8'h0);
    sts_tdata[1] = 8'h80; sts_tvalid[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray sts_tready", 72'(sts_tready[1]), 72'd0);
      chk("stray done", 72'(done[1]), 72'd0);
    end
    sts_tvalid[1] = 1'b0;
    xfer(1, $urandom, 23'($urandom_range(1, 8388607)), 1, 2, 0, 8'h0);

    // Fastest round trip: done three cycles after the request
    t0 = model_tag[0];
    cmd_tready[0] = 1'b1; sts_tvalid[0] = 1'b1; sts_tdata[0] = {4'h8, t0};
    req[0] = 1'b1; addr[0] = 32'h40; btt[0] = 23'd8;
    @(negedge clk);
    req[0] = 1'b0;
    chk("fast n+1 done", 72'(done[0]), 72'd0);
    chk("fast n+1 tdata", cmd_tdata[0], ref_cmd(32'h40, 23'd8, t0));
    @(negedge clk);
    chk("fast n+2 done", 72'(done[0]), 72'd0);
    @(negedge clk);
    chk("fast n+3 done", 72'(done[0]), 72'd1);
    chk("fast n+3 error", 72'(err[0]), 72'd0);
    cmd_tready[0] = 1'b0; sts_tvalid[0] = 1'b0;
    model_tag[0] = model_tag[0] + 4'd1;
    @(negedge clk);

    // 17 loads (tag wrap) with concurrent playback
    do_reset();
    fork
      begin
        for (int i = 0; i < 17; i++)
          xfer(0, $urandom, 23'($urandom_range(1, 8388607)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 8'h0);
      end
      begin
        for (int i = 0; i < 8; i++)
          xfer(1, $urandom, 23'($urandom_range(1, 8388607)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 8'h0);
      end
    join
    xfer(0, 32'h8, 23'd16, 0, 0, 1, 8'h81);

    // Reset mid-CMD and mid-STS
    req[0] = 1'b1; addr[0] = 32'h1234; btt[0] = 23'd32;
    @(negedge clk);
    req[0] = 1'b0;
    chk("midcmd tvalid", 72'(cmd_tvalid[0]), 72'd1);
    do_reset();
    req[1] = 1'b1; addr[1] = 32'h5678; btt[1] = 23'd32; cmd_tready[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    chk("midsts sts_tready", 72'(sts_tready[1]), 72'd1);
    do_reset();

    // Sticky datamover error
    mm2s_err = 1'b1;
    @(negedge clk);
    mm2s_err = 1'b0;
    chk("sticky set", 72'(dm_err_sticky), 72'd1);
    repeat (3) @(negedge clk);
    chk("sticky held", 72'(dm_err_sticky), 72'd1);
    do_reset();
    s2mm_err = 1'b1;
    @(negedge clk);
    s2mm_err = 1'b0;
    chk("sticky s2mm", 72'(dm_err_sticky), 72'd1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
